// File: rtl/msrv32_mdu_pkg.sv
// Shared constants and types for the RV32M iterative multiply/divide unit.
package msrv32_mdu_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int mdu_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/msrv32_mdu_sign_fix.sv
// Two-lane conditional two's-complement negation: operand magnitudes on the
// input side, product/quotient and remainder sign restoration on the output side.
module msrv32_mdu_sign_fix #(
    parameter int A_W = 32,
    parameter int B_W = 32
) (
    input  logic [A_W-1:0] a_in,
    input  logic           a_neg,
    input  logic [B_W-1:0] b_in,
    input  logic           b_neg,
    output logic [A_W-1:0] a_out,
    output logic [B_W-1:0] b_out
);

    assign a_out = a_neg ? (~a_in + 1'b1) : a_in;
    assign b_out = b_neg ? (~b_in + 1'b1) : b_in;

endmodule

// File: rtl/msrv32_mdu.sv
// RV32M multiply/divide unit: shift-add multiplier and restoring divider, one bit
// per cycle. Define MSRV32_MDU_DIV_EN to build the divider; otherwise divides are illegal.
module msrv32_mdu
    import msrv32_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic             start_in,
    input  logic [2:0]       funct3_in,
    input  logic [WIDTH-1:0] op_1_in,
    input  logic [WIDTH-1:0] op_2_in,
    input  logic             flush_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] result_out,
    output logic             illegal_out
);

    localparam int CNT_W = mdu_cnt_w(WIDTH);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_e state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept, iterate, finish;

    logic [2:0]       f3_q;
    logic             sign1_q, sign2_q, fast_q, illegal_q;
    logic [WIDTH-1:0] opnd_q, acc_hi, acc_lo;

    logic signed [WIDTH-1:0] op_1_s, op_2_s;
    logic             op1_signed, op2_signed, sign1, sign2;
    logic [WIDTH-1:0] mag1, mag2;
    logic             fast_in, illegal_in;
    logic [WIDTH-1:0] fast_res;

    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] step_nxt;
    logic [2*WIDTH-1:0] fix_a_in, fix_a_out;
    logic [WIDTH-1:0]   fix_b_out, result_sel;

    assign ready_out = (state == ST_IDLE) || (state == ST_DONE);
    assign accept    = start_in && ready_out && !flush_in;

    always_comb begin
        op1_signed = 1'b0;
        op2_signed = 1'b0;
        case (funct3_in)
            F3_MULH, F3_DIV, F3_REM: begin
                op1_signed = 1'b1;
                op2_signed = 1'b1;
            end
            F3_MULHSU: op1_signed = 1'b1;
            default: ;
        endcase
    end

    assign op_1_s = op_1_in;
    assign op_2_s = op_2_in;
    assign sign1  = op1_signed && (op_1_s < 0);
    assign sign2  = op2_signed && (op_2_s < 0);

    msrv32_mdu_sign_fix #(.A_W(WIDTH), .B_W(WIDTH)) u_in_fix (
        .a_in  (op_1_in),
        .a_neg (sign1),
        .b_in  (op_2_in),
        .b_neg (sign2),
        .a_out (mag1),
        .b_out (mag2)
    );

    always_comb begin
        fast_in    = 1'b0;
        illegal_in = 1'b0;
        fast_res   = '0;
`ifdef MSRV32_MDU_DIV_EN
        if (funct3_in[2]) begin
            if (op_2_in == '0) begin
                fast_in  = 1'b1;
                fast_res = funct3_in[1] ? op_1_in : ALL_ONES;
            end else if (!funct3_in[0] && (op_1_in == MIN_NEG) && (op_2_in == ALL_ONES)) begin
                fast_in  = 1'b1;
                fast_res = funct3_in[1] ? '0 : op_1_in;
            end
        end
`else
        if (funct3_in[2]) begin
            fast_in    = 1'b1;
            illegal_in = 1'b1;
        end
`endif
    end

    // Fast-path ops preload the counter to WIDTH so they spend one BUSY cycle
    // and leave through the same registered output edge as iterative ops.
    always_comb begin
        state_nxt = state;
        iterate   = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: state_nxt = accept ? ST_BUSY : ST_IDLE;
            ST_BUSY: begin
                if (cnt == CNT_W'(WIDTH)) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    iterate = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (flush_in) begin
            state_nxt = ST_IDLE;
            iterate   = 1'b0;
            finish    = 1'b0;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            valid_out   <= 1'b0;
            illegal_out <= 1'b0;
            result_out  <= '0;
        end else begin
            state       <= state_nxt;
            valid_out   <= finish;
            illegal_out <= finish && illegal_q;
            if (accept) begin
                cnt <= fast_in ? CNT_W'(WIDTH) : '0;
            end else if (iterate) begin
                cnt <= cnt + 1'b1;
            end
            if (finish) begin
                result_out <= result_sel;
            end
        end
    end

    // acc_lo holds the multiplier (shifted out) or the dividend/quotient;
    // acc_hi accumulates the product high half or the partial remainder.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (accept) begin
            f3_q      <= funct3_in;
            sign1_q   <= sign1;
            sign2_q   <= sign2;
            fast_q    <= fast_in;
            illegal_q <= illegal_in;
            acc_hi    <= '0;
            if (fast_in) begin
                acc_lo <= fast_res;
            end else if (funct3_in[2]) begin
                acc_lo <= mag1;
                opnd_q <= mag2;
            end else begin
                acc_lo <= mag2;
                opnd_q <= mag1;
            end
        end else if (iterate) begin
            {acc_hi, acc_lo} <= step_nxt;
        end
    end

    assign mul_addend = acc_lo[0] ? opnd_q : '0;
    assign mul_sum    = {1'b0, acc_hi} + {1'b0, mul_addend};

`ifdef MSRV32_MDU_DIV_EN
    logic [WIDTH:0] div_shift, div_diff;

    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    // div_diff[WIDTH] is the borrow: set when the divisor does not fit.
    always_comb begin
        if (f3_q[2]) begin
            step_nxt = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            step_nxt = {mul_sum, acc_lo[WIDTH-1:1]};
        end
    end
`else
    assign step_nxt = {mul_sum, acc_lo[WIDTH-1:1]};
`endif

    assign fix_a_in = f3_q[2] ? {{WIDTH{1'b0}}, acc_lo} : {acc_hi, acc_lo};

    msrv32_mdu_sign_fix #(.A_W(2*WIDTH), .B_W(WIDTH)) u_out_fix (
        .a_in  (fix_a_in),
        .a_neg (sign1_q ^ sign2_q),
        .b_in  (acc_hi),
        .b_neg (sign1_q),
        .a_out (fix_a_out),
        .b_out (fix_b_out)
    );

    always_comb begin
        result_sel = fix_a_out[2*WIDTH-1:WIDTH];
        if (fast_q) begin
            result_sel = acc_lo;
        end else begin
            case (f3_q)
                F3_MUL, F3_DIV, F3_DIVU: result_sel = fix_a_out[WIDTH-1:0];
                F3_REM, F3_REMU:         result_sel = fix_b_out;
                default:                 result_sel = fix_a_out[2*WIDTH-1:WIDTH];
            endcase
        end
    end

endmodule

// File: tb/tb_msrv32_mdu.sv
// Directed-vector bench for msrv32_mdu; divide vectors follow MSRV32_MDU_DIV_EN.
module tb_msrv32_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_1, op_2;
    logic        flush;
    logic        ready, valid, illegal;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    msrv32_mdu #(.WIDTH(32)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .start_in             (start),
        .funct3_in            (funct3),
        .op_1_in              (op_1),
        .op_2_in              (op_2),
        .flush_in             (flush),
        .ready_out            (ready),
        .valid_out            (valid),
        .result_out           (result),
        .illegal_out          (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Presents a request, lets it be accepted on the next edge, then scrambles
    // the operands to show they are not re-sampled.
    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        funct3 = f3;
        op_1   = a;
        op_2   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op_1   = 32'h1234_5678;
        op_2   = 32'h0000_0003;
        funct3 = 3'b000;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!valid && lat < 100);
    endtask

    task automatic count_valid(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (valid) seen++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                       input logic exp_ill);
        int lat;
        launch(f3, a, b);
        wait_valid(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, result, exp);
        chk({tag, "_ill"}, illegal, exp_ill);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, valid, 1'b0);
        chk({tag, "_hold"}, result, exp);
    endtask

    initial begin
        int lat, seen;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = 3'b000; op_1 = '0; op_2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_result", result, 32'h0);
        chk("rst_illegal", illegal, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
        run("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
        run("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
        run("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);

`ifdef MSRV32_MDU_DIV_EN
        run("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
        run("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
        run("divu",   3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        run("remu",   3'b111, 32'd100, 32'd7, 32'd2,  33, 1'b0);
        run("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        run("remu_z", 3'b111, 32'd5, 32'd0, 32'd5, 1, 1'b0);
        run("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
        run("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b0);
`else
        run("div_ill",  3'b100, 32'd10,  32'd2, 32'h0, 1, 1'b1);
        run("remu_ill", 3'b111, 32'd100, 32'd7, 32'h0, 1, 1'b1);
`endif
        run("mul_42", 3'b000, 32'd6, 32'd7, 32'd42, 33, 1'b0);

        // Flush ten cycles into an op.
        launch(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("busy_ready", ready, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_ready", ready, 1'b1);
        chk("flush_valid", valid, 1'b0);
        chk("flush_result", result, 32'd42);
        count_valid(40, seen);
        chk("flush_no_valid", seen, 0);

        // Start and flush on the same edge: not accepted.
        funct3 = 3'b000; op_1 = 32'd3; op_2 = 32'd3;
        start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_ready", ready, 1'b1);
        count_valid(40, seen);
        chk("flush_start_no_valid", seen, 0);

        // Reset mid-op.
        launch(3'b000, 32'd9, 32'd9);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_result", result, 32'h0);
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_valid", valid, 1'b0);
        count_valid(40, seen);
        chk("midrst_no_valid", seen, 0);

        // Back-to-back: second request issued in the DONE cycle.
        launch(3'b000, 32'd5, 32'd11);
        wait_valid(lat);
        chk("b2b_first_lat", lat, 33);
        chk("b2b_first_res", result, 32'd55);
        chk("b2b_done_ready", ready, 1'b1);
        launch(3'b000, 32'hFFFF_FFFF, 32'd4);
        chk("b2b_accepted", ready, 1'b0);
        wait_valid(lat);
        chk("b2b_second_lat", lat, 33);
        chk("b2b_second_res", result, 32'hFFFF_FFFC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
